door_timer: RTL
===============

DOOR_TIMER -- requirements
Module: door_timer

Interface
REQ-001 Parameter OPEN_TICKS, default 4, number of slow-clock ticks the door motor runs to open the door.
REQ-002 Parameter HOLD_TICKS, default 8, number of ticks the door is held open.
REQ-003 Parameter CLOSE_TICKS, default 4, number of ticks the door motor runs to close the door.
REQ-004 Parameter TW, default 8, width of the internal tick counter; all TICKS parameters SHALL be in 1..2^TW-1.
REQ-005 clk  in  1  system clock; all logic on posedge.
REQ-006 n_rst  in  1  reset; asynchronous, active-low.
REQ-007 slow_clk  in  1  divided clock level, from the clock divider's clkOut.
REQ-008 past_slow_clk  in  1  slow_clk delayed one clk, from the divider's past_clkOut.
REQ-009 open_req  in  1  level; request to open or keep open the door.
REQ-010 obstruct  in  1  level; door sensor blocked.
REQ-011 motor_open  out  1  high in OPENING.
REQ-012 motor_close  out  1  high in CLOSING.
REQ-013 door_open  out  1  high in HOLD.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-clk pulse on the CLOSING->IDLE transition.
REQ-016 state  out  2  current state encoding: IDLE=0, OPENING=1, HOLD=2, CLOSING=3.

Function
REQ-017 tick SHALL be slow_clk & ~past_slow_clk, combinational, one clk wide per slow-clock rising edge.
REQ-018 All state and counter updates SHALL occur on posedge clk; outputs SHALL be registered or decoded from registered state, with no path from inputs to outputs.
REQ-019 The counter SHALL clear to 0 on every state change.
REQ-020 In a timed state with limit N, on tick: if cnt==N-1 the FSM advances and cnt becomes 0; otherwise cnt increments; a timed phase therefore lasts exactly N ticks.
REQ-021 IDLE: if open_req=1, go to OPENING next clk; no tick is required.
REQ-022 OPENING: after OPEN_TICKS ticks, go to HOLD; open_req is ignored.
REQ-023 HOLD: open_req=1 or obstruct=1 clears cnt and holds the state; otherwise, after HOLD_TICKS ticks, go to CLOSING.
REQ-024 CLOSING: open_req=1 goes to OPENING with cnt=0 and no done pulse; otherwise, after CLOSE_TICKS ticks, go to IDLE and pulse done.
REQ-025 A reopen request in the same clk as a final CLOSING tick SHALL win: the next state is OPENING and no done pulse is issued.
REQ-026 Counter arithmetic SHALL be TW bits unsigned and SHALL never wrap, because REQ-020 bounds it.

Reset
REQ-027 n_rst=0 SHALL immediately force state=IDLE, cnt=0, done=0, with motor_open=motor_close=door_open=busy=0, regardless of clk.
REQ-028 Reset asserted mid-phase SHALL abandon the phase; after release the block SHALL wait in IDLE for open_req.

Configuration
REQ-029 Macro DOOR_OBSTRUCT_REOPEN_EN: when defined, obstruct=1 in CLOSING SHALL go to OPENING with cnt=0, with the same priority as open_req.
REQ-030 Without DOOR_OBSTRUCT_REOPEN_EN, obstruct SHALL be ignored in CLOSING; HOLD behaviour per REQ-023 is unchanged.

Structure
REQ-031 Package door_pkg SHALL hold the state_t enum (2-bit encoding of REQ-016) and default constants for OPEN_TICKS, HOLD_TICKS and CLOSE_TICKS.
REQ-032 Sub-module tick_detect SHALL compute tick from slow_clk and past_slow_clk; all other logic stays in door_timer.

Verification (OPEN=3, HOLD=5, CLOSE=3; slow clock = clk/8 from the clock divider)
REQ-033 open_req pulsed 1 clk in IDLE -> OPENING 3 ticks, HOLD 5 ticks, CLOSING 3 ticks, then a single done pulse and state=0.
REQ-034 open_req held high across HOLD -> door_open stays 1; CLOSING entered exactly 5 ticks after open_req falls.
REQ-035 open_req asserted at the 2nd CLOSING tick -> state=1 the next clk, no done pulse, then a full 3-tick OPENING.
REQ-036 obstruct=1 in CLOSING -> with macro, state=1 next clk; without macro, CLOSING completes and done pulses.
REQ-037 n_rst dropped mid-HOLD, asynchronously between clk edges -> all outputs 0 and state=0 immediately; after release, no motion until open_req.
REQ-038 slow_clk held constant, so no ticks -> the FSM stays in OPENING indefinitely and cnt does not change.

Source files
------------

// File: rtl/door_pkg.sv
`default_nettype none
// ============================================================================
// Module   : door_pkg
// Purpose  : Shared types and default timing constants for the door timer.
//            state_t uses the externally visible 2-bit state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package door_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPENING = 2'd1,
        ST_HOLD    = 2'd2,
        ST_CLOSING = 2'd3
    } state_t;

    // Default phase lengths, in slow-clock ticks, and counter width.
    localparam int c_open_ticks_dflt  = 4;
    localparam int c_hold_ticks_dflt  = 8;
    localparam int c_close_ticks_dflt = 4;
    localparam int c_tw_dflt          = 8;

endpackage : door_pkg
`default_nettype wire

// File: rtl/door_timer_tick_detect.sv
`default_nettype none
// ============================================================================
// Module   : tick_detect
// Purpose  : Rising-edge detector for the divided slow clock. Produces a
//            one-clk-wide tick for every slow-clock rising edge.
// Ports    : slow_clk      in  divided clock level
//            past_slow_clk in  slow_clk delayed by one clk
//            tick          out one-clk pulse per slow-clock rising edge
// Revision : 1.0 - initial release
// ============================================================================
module tick_detect (
    input  logic slow_clk,
    input  logic past_slow_clk,
    output logic tick
);

    assign tick = slow_clk & ~past_slow_clk;

endmodule : tick_detect
`default_nettype wire

// File: rtl/door_timer.sv
`default_nettype none
// ============================================================================
// Module   : door_timer
// Purpose  : Door motor sequencer IDLE -> OPENING -> HOLD -> CLOSING -> IDLE,
//            each timed phase measured in slow-clock ticks.
// Ports    : clk           in  system clock, posedge
//            n_rst         in  asynchronous active-low reset
//            slow_clk      in  divided clock level
//            past_slow_clk in  slow_clk delayed one clk
//            open_req      in  open / keep-open request (level)
//            obstruct      in  door sensor blocked (level)
//            motor_open    out high in OPENING
//            motor_close   out high in CLOSING
//            door_open     out high in HOLD
//            busy          out high outside IDLE
//            done          out one-clk pulse on CLOSING -> IDLE
//            state         out current state encoding
// Config   : DOOR_OBSTRUCT_REOPEN_EN - when defined, obstruct in CLOSING
//            reopens the door exactly like open_req.
// Revision : 1.0 - initial release
// ============================================================================
module door_timer
    import door_pkg::*;
#(
    parameter int OPEN_TICKS  = c_open_ticks_dflt,
    parameter int HOLD_TICKS  = c_hold_ticks_dflt,
    parameter int CLOSE_TICKS = c_close_ticks_dflt,
    parameter int TW          = c_tw_dflt
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       slow_clk,
    input  logic       past_slow_clk,
    input  logic       open_req,
    input  logic       obstruct,
    output logic       motor_open,
    output logic       motor_close,
    output logic       door_open,
    output logic       busy,
    output logic       done,
    output logic [1:0] state
);

    // Terminal counter values: a phase of N ticks ends on the tick seen
    // while the counter holds N-1, so the counter never exceeds N-1.
    localparam logic [TW-1:0] c_open_last  = TW'(OPEN_TICKS - 1);
    localparam logic [TW-1:0] c_hold_last  = TW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0] c_close_last = TW'(CLOSE_TICKS - 1);

    state_t        r_state;
    logic [TW-1:0] r_cnt;
    logic          r_done;

    state_t        w_state_next;
    logic [TW-1:0] w_cnt_next;
    logic          w_done_next;
    logic          w_tick;
    logic          w_reopen;

    tick_detect u_tick_detect (
        .slow_clk      (slow_clk),
        .past_slow_clk (past_slow_clk),
        .tick          (w_tick)
    );

    // Conditions that abort CLOSING and send the door back to OPENING.
`ifdef DOOR_OBSTRUCT_REOPEN_EN
    assign w_reopen = open_req | obstruct;
`else
    assign w_reopen = open_req;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (open_req) begin
                    w_state_next = ST_OPENING;
                    w_cnt_next   = '0;
                end
            end
            ST_OPENING: begin
                if (w_tick) begin
                    if (r_cnt == c_open_last) begin
                        w_state_next = ST_HOLD;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // Any request or obstruction restarts the hold time.
                if (open_req || obstruct) begin
                    w_cnt_next = '0;
                end else if (w_tick) begin
                    if (r_cnt == c_hold_last) begin
                        w_state_next = ST_CLOSING;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            ST_CLOSING: begin
                // Reopen takes priority even over the final closing tick.
                if (w_reopen) begin
                    w_state_next = ST_OPENING;
                    w_cnt_next   = '0;
                end else if (w_tick) begin
                    if (r_cnt == c_close_last) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    // Outputs decode only registered state, so reset clears them at once.
    assign motor_open  = (r_state == ST_OPENING);
    assign motor_close = (r_state == ST_CLOSING);
    assign door_open   = (r_state == ST_HOLD);
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign state       = r_state;

endmodule : door_timer
`default_nettype wire
